// File: rtl/icache_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_line_responder (with icache_line_responder_pkg)      |
// | Description : Single-line instruction cache responder. Serves fetch       |
// |               requests from one 128-bit line buffer. It reports           |
// |               translation and physical-range faults, and it refills the   |
// |               line from memory on a miss.                                 |
// | Ports       : clk_i, rst_i           - clock, sync active-high reset      |
// |               req_cpu_icache_i       - fetch request {valid,vaddr,inv}    |
// |               xlate_fault_i          - translation fault for this vaddr   |
// |               ready_o                - request accepted this cycle        |
// |               resp_icache_cpu_o      - fetch response (one-cycle pulse)   |
// |               refill_req_*           - line refill request handshake      |
// |               refill_resp_*          - refill data / bus error            |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+

package icache_line_responder_pkg;
   typedef struct packed {
      logic        valid;
      logic [39:0] vaddr;
      logic        invalidate_icache;
   } req_cpu_icache_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic        instr_access_fault;
      logic        instr_page_fault;
   } resp_icache_cpu_t;

   typedef logic [127:0] icache_line_t;
endpackage

module icache_line_responder
   import icache_line_responder_pkg::*;
#(
   parameter logic [39:0] ADDR_LIMIT = 40'h00_8000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  req_cpu_icache_t  req_cpu_icache_i,
   input  logic             xlate_fault_i,
   output logic             ready_o,
   output resp_icache_cpu_t resp_icache_cpu_o,
   output logic             refill_req_valid_o,
   output logic [39:0]      refill_req_addr_o,
   input  logic             refill_req_ready_i,
   input  logic             refill_resp_valid_i,
   input  icache_line_t     refill_resp_data_i,
   input  logic             refill_resp_error_i
);

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_REFILL_REQ  = 2'd1,
      ST_REFILL_WAIT = 2'd2,
      ST_RESPOND     = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   icache_line_t     r_line;
   logic [35:0]      r_tag;
   logic             r_line_valid;
   logic [39:2]      r_addr;        // word address of the request being refilled
   logic             r_inv_pending;
   resp_icache_cpu_t r_resp;
   resp_icache_cpu_t w_resp_next;

   logic             w_addr_fault;
   logic             w_hit;
   logic [31:0]      w_hit_word;
   logic [31:0]      w_refill_word;

   assign w_addr_fault  = (req_cpu_icache_i.vaddr >= ADDR_LIMIT);
   // An invalidate on the same cycle as a request takes effect first, so the
   // request sees an empty line and goes to memory.
   assign w_hit         = r_line_valid && !req_cpu_icache_i.invalidate_icache &&
                          (r_tag == req_cpu_icache_i.vaddr[39:4]);
   assign w_hit_word    = r_line[{req_cpu_icache_i.vaddr[3:2], 5'b00000} +: 32];
   assign w_refill_word = refill_resp_data_i[{r_addr[3:2], 5'b00000} +: 32];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and next response. The response is registered, so a value
   // built here appears on the port in the following cycle: one cycle after
   // acceptance for faults and hits, and during RESPOND for refills.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_resp_next  = '0;
      case (r_state)
         ST_IDLE: begin
            if (req_cpu_icache_i.valid) begin
               if (xlate_fault_i) begin
                  w_resp_next.valid            = 1'b1;
                  w_resp_next.instr_page_fault = 1'b1;
               end else if (w_addr_fault) begin
                  w_resp_next.valid              = 1'b1;
                  w_resp_next.instr_access_fault = 1'b1;
               end else if (w_hit) begin
                  w_resp_next.valid = 1'b1;
                  w_resp_next.data  = w_hit_word;
               end else begin
                  w_state_next = ST_REFILL_REQ;
               end
            end
         end
         ST_REFILL_REQ: begin
            if (refill_req_ready_i) begin
               w_state_next = ST_REFILL_WAIT;
            end
         end
         ST_REFILL_WAIT: begin
            if (refill_resp_valid_i) begin
               w_state_next      = ST_RESPOND;
               w_resp_next.valid = 1'b1;
               if (refill_resp_error_i) begin
                  w_resp_next.instr_access_fault = 1'b1;
               end else begin
                  w_resp_next.data = w_refill_word;
               end
            end
         end
         ST_RESPOND: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Line buffer, captured request and invalidate bookkeeping
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_line        <= '0;
         r_tag         <= '0;
         r_line_valid  <= 1'b0;
         r_addr        <= '0;
         r_inv_pending <= 1'b0;
         r_resp        <= '0;
      end else begin
         r_resp <= w_resp_next;

         case (r_state)
            ST_IDLE: begin
               if (req_cpu_icache_i.invalidate_icache) begin
                  r_line_valid <= 1'b0;
               end
               if (req_cpu_icache_i.valid) begin
                  r_addr <= req_cpu_icache_i.vaddr[39:2];
               end
            end
            ST_REFILL_WAIT: begin
               if (refill_resp_valid_i) begin
                  r_line       <= refill_resp_data_i;
                  r_tag        <= r_addr[39:4];
                  r_line_valid <= !refill_resp_error_i;
               end
            end
            default: begin
            end
         endcase

         // An invalidate that arrives mid-transaction must not kill the
         // in-flight response. It is held here and applied on return to IDLE.
         if (r_state != ST_IDLE && req_cpu_icache_i.invalidate_icache) begin
            r_inv_pending <= 1'b1;
         end
         if (r_state != ST_IDLE && w_state_next == ST_IDLE) begin
            if (r_inv_pending || req_cpu_icache_i.invalidate_icache) begin
               r_line_valid <= 1'b0;
            end
            r_inv_pending <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ready_o            = (r_state == ST_IDLE);
   assign refill_req_valid_o = (r_state == ST_REFILL_REQ);
   assign refill_req_addr_o  = refill_req_valid_o ? {r_addr[39:4], 4'b0000} : 40'd0;
   assign resp_icache_cpu_o  = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_icache_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_icache_line_responder                                    |
// | Description : Self-checking bench for icache_line_responder. It applies   |
// |               a vector table plus hand-written refill, invalidate,        |
// |               backpressure and reset sequences. Responses are checked     |
// |               against a queue of expected values.                         |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_icache_line_responder;
   import icache_line_responder_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   req_cpu_icache_t  req;
   logic             xlate;
   logic             ready;
   resp_icache_cpu_t resp;
   logic             rf_req_valid;
   logic [39:0]      rf_req_addr;
   logic             rf_req_ready;
   logic             rf_resp_valid;
   icache_line_t     rf_resp_data;
   logic             rf_resp_error;

   icache_line_responder #(.ADDR_LIMIT(40'h00_8000_0000)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .req_cpu_icache_i    (req),
      .xlate_fault_i       (xlate),
      .ready_o             (ready),
      .resp_icache_cpu_o   (resp),
      .refill_req_valid_o  (rf_req_valid),
      .refill_req_addr_o   (rf_req_addr),
      .refill_req_ready_i  (rf_req_ready),
      .refill_resp_valid_i (rf_resp_valid),
      .refill_resp_data_i  (rf_resp_data),
      .refill_resp_error_i (rf_resp_error)
   );

   always #5 clk = ~clk;

   int               n_cmp = 0;
   int               n_bad = 0;
   resp_icache_cpu_t exp_q[$];

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endfunction

   // Memory model: a recognisable word per (line address, word index).
   function automatic logic [31:0] mem_word(input logic [39:0] a, input logic [1:0] k);
      return {a[27:4], 4'hC, k, 2'b00};
   endfunction

   function automatic icache_line_t mem_line(input logic [39:0] a);
      return {mem_word(a, 2'd3), mem_word(a, 2'd2), mem_word(a, 2'd1), mem_word(a, 2'd0)};
   endfunction

   function automatic resp_icache_cpu_t r_ok(input logic [31:0] d);
      resp_icache_cpu_t r;
      r = '0; r.valid = 1'b1; r.data = d;
      return r;
   endfunction

   function automatic resp_icache_cpu_t r_pf();
      resp_icache_cpu_t r;
      r = '0; r.valid = 1'b1; r.instr_page_fault = 1'b1;
      return r;
   endfunction

   function automatic resp_icache_cpu_t r_af();
      resp_icache_cpu_t r;
      r = '0; r.valid = 1'b1; r.instr_access_fault = 1'b1;
      return r;
   endfunction

   // Response monitor: each valid response pops the scoreboard. Idle cycles
   // must present an all-zero response.
   always @(negedge clk) begin
      if (!rst) begin
         if (resp.valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_resp: got %h expected no response", resp);
            end else begin
               check("resp", resp, exp_q.pop_front());
            end
         end else begin
            check("resp_idle_zero", resp, '0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40 && !ready; i++) tick();
      check("ready_before_req", ready, 1'b1);
   endtask

   task automatic send(input logic [39:0] a, input logic xl, input logic inv,
                       input logic push, input resp_icache_cpu_t e);
      wait_ready();
      req.valid = 1'b1; req.vaddr = a; req.invalidate_icache = inv; xlate = xl;
      if (push) exp_q.push_back(e);
      tick();
      req = '0; xlate = 1'b0;
   endtask

   // Plays the memory side of one refill. Options: stall cycles before the
   // request is accepted, invalidate while waiting, and reset while waiting.
   task automatic serve(input logic [39:0] exp_addr, input int delay, input icache_line_t line,
                        input logic err, input logic inv_wait, input logic abort);
      for (int i = 0; i < 20 && !rf_req_valid; i++) tick();
      check("refill_valid", rf_req_valid, 1'b1);
      check("refill_addr", rf_req_addr, exp_addr);
      for (int d = 0; d < delay; d++) begin
         req.valid = 1'b1; req.vaddr = 40'h1000;   // must be ignored
         tick();
         req = '0;
         check("bp_valid", rf_req_valid, 1'b1);
         check("bp_addr", rf_req_addr, exp_addr);
         check("bp_ready", ready, 1'b0);
      end
      rf_req_ready = 1'b1;
      tick();
      rf_req_ready = 1'b0;
      check("refill_drop", rf_req_valid, 1'b0);
      check("wait_not_ready", ready, 1'b0);
      tick();
      if (inv_wait) begin
         req.invalidate_icache = 1'b1;
         tick();
         req = '0;
      end
      if (abort) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
      end
      rf_resp_valid = 1'b1; rf_resp_data = line; rf_resp_error = err;
      tick();
      rf_resp_valid = 1'b0; rf_resp_data = '0; rf_resp_error = 1'b0;
   endtask

   task automatic check_no_refill();
      for (int i = 0; i < 2; i++) begin
         check("no_refill", rf_req_valid, 1'b0);
         tick();
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("drain", exp_q.size(), 0);
      tick();
   endtask

   typedef struct {
      logic [39:0]      vaddr;
      logic             xl;
      logic             inv;
      logic             err;
      logic             refill;
      resp_icache_cpu_t expr;
   } vec_t;

   vec_t         vecs[14];
   icache_line_t line_l;

   initial begin
      line_l = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

      vecs[0]  = '{40'h00_0000_3004, 1'b0, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h3000, 2'd1))};
      vecs[1]  = '{40'h00_0000_3008, 1'b0, 1'b0, 1'b0, 1'b0, r_ok(mem_word(40'h3000, 2'd2))};
      vecs[2]  = '{40'h00_0000_300C, 1'b0, 1'b0, 1'b0, 1'b0, r_ok(mem_word(40'h3000, 2'd3))};
      vecs[3]  = '{40'h00_0000_3000, 1'b0, 1'b0, 1'b0, 1'b0, r_ok(mem_word(40'h3000, 2'd0))};
      vecs[4]  = '{40'h00_0000_4000, 1'b1, 1'b0, 1'b0, 1'b0, r_pf()};
      vecs[5]  = '{40'h00_0000_3004, 1'b0, 1'b0, 1'b0, 1'b0, r_ok(mem_word(40'h3000, 2'd1))};
      vecs[6]  = '{40'h00_8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, r_af()};
      vecs[7]  = '{40'h00_7FFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h7FFF_FFF0, 2'd3))};
      vecs[8]  = '{40'h00_7FFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0, r_ok(mem_word(40'h7FFF_FFF0, 2'd2))};
      vecs[9]  = '{40'h00_0000_5000, 1'b0, 1'b0, 1'b1, 1'b1, r_af()};
      vecs[10] = '{40'h00_0000_5004, 1'b0, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h5000, 2'd1))};
      vecs[11] = '{40'h00_0000_5008, 1'b0, 1'b1, 1'b0, 1'b1, r_ok(mem_word(40'h5000, 2'd2))};
      vecs[12] = '{40'h00_0000_500C, 1'b1, 1'b0, 1'b0, 1'b0, r_pf()};
      vecs[13] = '{40'h90_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, r_pf()};

      rst = 1'b1; req = '0; xlate = 1'b0; rf_req_ready = 1'b0;
      rf_resp_valid = 1'b0; rf_resp_data = '0; rf_resp_error = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_ready", ready, 1'b1);
      check("reset_resp", resp, '0);
      check("reset_refill_valid", rf_req_valid, 1'b0);
      check("reset_refill_addr", rf_req_addr, 40'd0);

      // Miss then hit on the known line pattern.
      send(40'h1008, 1'b0, 1'b0, 1'b1, r_ok(32'h3333_3333));
      serve(40'h1000, 0, line_l, 1'b0, 1'b0, 1'b0);
      drain();
      send(40'h100C, 1'b0, 1'b0, 1'b1, r_ok(32'h4444_4444));
      check_no_refill();
      drain();

      // Invalidate together with a request to the valid line forces a refill.
      send(40'h1004, 1'b0, 1'b1, 1'b1, r_ok(32'h2222_2222));
      serve(40'h1000, 0, line_l, 1'b0, 1'b0, 1'b0);
      drain();

      // Invalidate while waiting: response delivered, line dropped afterwards.
      send(40'h6000, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h6000, 2'd0)));
      serve(40'h6000, 1, mem_line(40'h6000), 1'b0, 1'b1, 1'b0);
      drain();
      send(40'h6004, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h6000, 2'd1)));
      serve(40'h6000, 0, mem_line(40'h6000), 1'b0, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 14; i++) begin
         send(vecs[i].vaddr, vecs[i].xl, vecs[i].inv, 1'b1, vecs[i].expr);
         if (vecs[i].refill)
            serve({vecs[i].vaddr[39:4], 4'h0}, i % 3, mem_line(vecs[i].vaddr), vecs[i].err, 1'b0, 1'b0);
         else
            check_no_refill();
         drain();
      end

      // Five cycles of refill backpressure.
      send(40'h8000, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h8000, 2'd0)));
      serve(40'h8000, 5, mem_line(40'h8000), 1'b0, 1'b0, 1'b0);
      drain();

      // Reset while waiting for refill data: no response for that request.
      send(40'h7000, 1'b0, 1'b0, 1'b0, r_ok(32'h0));
      serve(40'h7000, 0, mem_line(40'h7000), 1'b0, 1'b0, 1'b1);
      check("abort_ready", ready, 1'b1);
      check("abort_refill_valid", rf_req_valid, 1'b0);
      repeat (3) tick();
      check("abort_queue_empty", exp_q.size(), 0);
      // The line held before the reset must be invalid now.
      send(40'h8004, 1'b0, 1'b0, 1'b1, r_ok(mem_word(40'h8000, 2'd1)));
      serve(40'h8000, 0, mem_line(40'h8000), 1'b0, 1'b0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/icache_line_responder.md
ICACHE_LINE_RESPONDER -- requirements
Module: icache_line_responder

Interface
REQ-001 Parameter: ADDR_LIMIT, default 40'h00_8000_0000, first illegal physical fetch address; fetches at or above it fault.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 req_cpu_icache_i  in  req_cpu_icache_t  {valid, vaddr[39:0], invalidate_icache} from fetch.
REQ-005 xlate_fault_i  in  1  translation fault for the vaddr presented this cycle.
REQ-006 ready_o  out  1  responder can accept a request this cycle.
REQ-007 resp_icache_cpu_o  out  resp_icache_cpu_t  {valid, data[31:0], instr_access_fault, instr_page_fault} to fetch.
REQ-008 refill_req_valid_o  out  1  line refill request to memory.
REQ-009 refill_req_addr_o  out  40  line-aligned refill address, bits [3:0] = 0.
REQ-010 refill_req_ready_i  in  1  memory accepts refill request.
REQ-011 refill_resp_valid_i  in  1  refill data valid, single-cycle.
REQ-012 refill_resp_data_i  in  128  icache_line_t; word k at bits [32k+31:32k].
REQ-013 refill_resp_error_i  in  1  refill bus error, qualified by refill_resp_valid_i.

Function
REQ-014 State: one 128-bit line buffer, 36-bit tag (vaddr[39:4]), line_valid bit, captured request address, inv_pending bit.
REQ-015 FSM states IDLE, REFILL_REQ, REFILL_WAIT, RESPOND; ready_o = 1 only in IDLE.
REQ-016 Request accepted only when req.valid && IDLE; requests in other states ignored (fetch replays).
REQ-017 Priority on acceptance: xlate_fault_i > (vaddr >= ADDR_LIMIT) > hit > miss.
REQ-018 Page fault: resp.valid=1, instr_page_fault=1, access_fault=0, data=0 at cycle N+1; no refill; line state unchanged.
REQ-019 Address fault: resp.valid=1, instr_access_fault=1, page_fault=0, data=0 at N+1; no refill.
REQ-020 Hit (line_valid && tag match): resp.valid=1, data = word vaddr[3:2] of buffer at N+1; FSM stays IDLE.
REQ-021 Miss: IDLE->REFILL_REQ at N+1; refill_req_valid_o=1, refill_req_addr_o={vaddr[39:4],4'b0} held stable until refill_req_ready_i.
REQ-022 REFILL_REQ->REFILL_WAIT on cycle refill_req_ready_i=1; refill_req_valid_o drops next cycle.
REQ-023 REFILL_WAIT->RESPOND on refill_resp_valid_i; buffer, tag captured; line_valid = !refill_resp_error_i.
REQ-024 RESPOND lasts one cycle: resp.valid=1; data = selected word, or 0 with instr_access_fault=1 on error; then IDLE.
REQ-025 resp.valid is a one-cycle pulse per accepted request; all resp fields 0 when resp.valid=0.
REQ-026 vaddr[1:0] ignored; alignment checking out of scope.
REQ-027 invalidate_icache in IDLE clears line_valid at that edge; if valid asserted same cycle, request evaluated as miss.
REQ-028 invalidate_icache outside IDLE sets inv_pending; in-flight response still delivered; line_valid cleared and inv_pending cleared on entering IDLE.
REQ-029 refill_resp_valid_i outside REFILL_WAIT ignored.
REQ-030 Back-to-back hits: one response per cycle, no bubbles.

Reset
REQ-031 rst_i=1 at any edge: FSM=IDLE, line_valid=0, inv_pending=0, all outputs 0 except ready_o=1 the cycle after reset releases.
REQ-032 Reset mid-refill abandons transaction; late refill response ignored; no response issued for aborted request.

Verification
REQ-033 Miss then hit: req 40'h1008, ready_i immediately, resp line 128'h4444_3333_2222_1111... -> refill_addr 40'h1000, resp data word2; next req 40'h100C hit -> data word3 one cycle later, no refill.
REQ-034 Faults: xlate_fault_i=1 with vaddr 40'h90_0000_0000 -> page_fault=1 only at N+1; same vaddr, xlate_fault_i=0 -> access_fault=1, no refill_req.
REQ-035 Refill error: req 40'h2000, refill_resp_error_i=1 -> access_fault=1, data=0; repeat 40'h2000 -> new refill (line invalid).
REQ-036 Invalidate: hit line 40'h1000, then invalidate_icache+valid 40'h1004 same cycle -> refill issued; invalidate during REFILL_WAIT -> response delivered, next same-line req refills again.
REQ-037 Backpressure: refill_req_ready_i low 5 cycles -> valid/addr stable throughout, requests ignored, ready_o=0.
REQ-038 Reset in REFILL_WAIT, then refill_resp_valid_i pulse -> no resp.valid, ready_o=1, line_valid=0.
